angle_finder: RTL and testbench

Sequential inverse-trigonometric unit: given a fixed-point sine or cosine value, returns the integer angle in degrees (0–90) whose table value first meets or exceeds it. It performs a fixed-length binary search over an internal 91-entry quarter-wave sine table, with a start/busy/done handshake. It sits beside the forward angle-to-value lookup in the datapath and reuses its encoding: `op_selector` 0 = sine, 1 = cosine; 32-bit angle and value buses.

---
 rtl/angle_finder.sv | 129 ++++++++++++
 tb/tb_angle_finder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/angle_finder.sv
// angle_finder: sequential inverse sine/cosine. Binary-searches a 91-entry
// quarter-wave sine ROM for the smallest whole degree whose entry meets the input.
module angle_finder #(
  parameter int unsigned ITER = 7,
  parameter int unsigned FRAC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op_selector,
  input  logic [31:0] value,
  output logic [31:0] angle,
  output logic        busy,
  output logic        done,
  output logic        out_of_range
);

  localparam int unsigned CNT_W   = $clog2(ITER + 1);
  localparam logic [31:0] ONE     = 32'd1 << FRAC;
  localparam logic [6:0]  MAX_DEG = 7'd90;

  // round(sin(d deg) * 65536); entry 31 is held at 33753.
  localparam logic [16:0] SIN_TBL [0:90] = '{
    17'd0,     17'd1144,  17'd2287,  17'd3430,  17'd4572,
    17'd5712,  17'd6850,  17'd7987,  17'd9121,  17'd10252,
    17'd11380, 17'd12505, 17'd13626, 17'd14742, 17'd15855,
    17'd16962, 17'd18064, 17'd19161, 17'd20252, 17'd21336,
    17'd22415, 17'd23486, 17'd24550, 17'd25607, 17'd26656,
    17'd27697, 17'd28729, 17'd29753, 17'd30767, 17'd31772,
    17'd32768, 17'd33753, 17'd34729, 17'd35693, 17'd36647,
    17'd37590, 17'd38521, 17'd39441, 17'd40348, 17'd41243,
    17'd42126, 17'd42995, 17'd43852, 17'd44695, 17'd45525,
    17'd46341, 17'd47143, 17'd47930, 17'd48703, 17'd49461,
    17'd50203, 17'd50931, 17'd51643, 17'd52339, 17'd53020,
    17'd53684, 17'd54332, 17'd54963, 17'd55578, 17'd56175,
    17'd56756, 17'd57319, 17'd57865, 17'd58393, 17'd58903,
    17'd59396, 17'd59870, 17'd60326, 17'd60764, 17'd61183,
    17'd61584, 17'd61966, 17'd62328, 17'd62672, 17'd62997,
    17'd63303, 17'd63589, 17'd63856, 17'd64104, 17'd64332,
    17'd64540, 17'd64729, 17'd64898, 17'd65048, 17'd65177,
    17'd65287, 17'd65376, 17'd65446, 17'd65496, 17'd65526,
    17'd65536
  };

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t           state, state_nxt;
  logic [31:0]      v, v_nxt;
  logic             op, op_nxt;
  logic [6:0]       lo, lo_nxt, hi, hi_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      angle_nxt;
  logic             oor_nxt, done_nxt;
  logic [7:0]       sum;
  logic [6:0]       mid, deg;

  assign busy = (state == SEARCH);

  always_comb begin
    // NOTE: every target gets a default first so no path through the case infers a latch.
    state_nxt = state;
    v_nxt     = v;
    op_nxt    = op;
    lo_nxt    = lo;
    hi_nxt    = hi;
    cnt_nxt   = cnt;
    angle_nxt = angle;
    oor_nxt   = out_of_range;
    done_nxt  = 1'b0;
    deg       = lo;
    sum       = {1'b0, lo} + {1'b0, hi};
    mid       = sum[7:1];

    case (state)
      IDLE: begin
        if (start) begin
          v_nxt     = value;
          op_nxt    = op_selector;
          lo_nxt    = 7'd0;
          hi_nxt    = MAX_DEG;
          cnt_nxt   = '0;
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        // A converged window stays put for the remaining fixed iterations.
        if (lo != hi) begin
          if ({15'd0, SIN_TBL[mid]} >= v) hi_nxt = mid;
          else                            lo_nxt = mid + 7'd1;
        end
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(ITER - 1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          oor_nxt   = (v > ONE);
          deg       = oor_nxt ? MAX_DEG : lo_nxt;
          angle_nxt = op ? 32'(MAX_DEG - deg) : 32'(deg);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      v            <= '0;
      op           <= 1'b0;
      lo           <= '0;
      hi           <= '0;
      cnt          <= '0;
      angle        <= '0;
      out_of_range <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      v            <= v_nxt;
      op           <= op_nxt;
      lo           <= lo_nxt;
      hi           <= hi_nxt;
      cnt          <= cnt_nxt;
      angle        <= angle_nxt;
      out_of_range <= oor_nxt;
      done         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_angle_finder.sv
// Self-checking bench for angle_finder: vector table, full-table sweep against a
// $sin-derived model, and hand-written handshake/reset sequences.
module tb_angle_finder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        op_selector = 1'b0;
  logic [31:0] value = '0;
  logic [31:0] angle;
  logic        busy, done, out_of_range;

  angle_finder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_selector(op_selector),
    .value(value), .angle(angle), .busy(busy), .done(done),
    .out_of_range(out_of_range)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] angle; logic oor; } exp_t;
  typedef struct { logic op; logic [31:0] value; logic [31:0] angle; logic oor; } vec_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   tbl_m[0:90];
  int   checks = 0, errors = 0;
  int   done_count = 0, cyc = 0, last_done = 0, prev_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic op, input logic [31:0] v);
    exp_t e;
    int   a = 90;
    e.oor = (v > 32'd65536);
    if (!e.oor)
      for (int d = 90; d >= 0; d--) if (32'(tbl_m[d]) >= v) a = d;
    e.angle = op ? 32'(90 - a) : 32'(a);
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done pulse pops and compares one expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin : mon
      exp_t e;
      prev_done = last_done;
      last_done = cyc;
      done_count++;
      if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("angle", angle, e.angle);
        check("out_of_range", {31'd0, out_of_range}, {31'd0, e.oor});
      end
    end
  end

  // Drive one request at a negedge; operands are scrambled once it is accepted.
  task automatic issue(input logic op, input logic [31:0] v, input exp_t e);
    start = 1'b1; op_selector = op; value = v;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; value = $urandom; op_selector = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check(name, 32'd0, 32'd1);
  endtask

  task automatic run(input logic op, input logic [31:0] v, input exp_t e);
    issue(op, v, e);
    wait_done("done_timeout");
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    exp_t e;
    int   c0;
    for (int d = 0; d <= 90; d++)
      tbl_m[d] = $rtoi($floor($sin(d * 3.14159265358979 / 180.0) * 65536.0 + 0.5));
    tbl_m[31] = 33753;  // documented anchor for entry 31

    vecs[0]  = '{1'b0, 32'd32768,        32'd30, 1'b0};
    vecs[1]  = '{1'b1, 32'd32768,        32'd60, 1'b0};
    vecs[2]  = '{1'b0, 32'd32769,        32'd31, 1'b0};
    vecs[3]  = '{1'b0, 32'd0,            32'd0,  1'b0};
    vecs[4]  = '{1'b1, 32'd0,            32'd90, 1'b0};
    vecs[5]  = '{1'b0, 32'd65536,        32'd90, 1'b0};
    vecs[6]  = '{1'b1, 32'd65536,        32'd0,  1'b0};
    vecs[7]  = '{1'b0, 32'd70000,        32'd90, 1'b1};
    vecs[8]  = '{1'b1, 32'd70000,        32'd0,  1'b1};
    vecs[9]  = '{1'b0, 32'd32768,        32'd30, 1'b0};
    vecs[10] = '{1'b0, 32'd33753,        32'd31, 1'b0};
    vecs[11] = '{1'b0, 32'd33754,        32'd32, 1'b0};
    vecs[12] = '{1'b1, 32'd1,            32'd89, 1'b0};
    vecs[13] = '{1'b0, 32'hFFFF_FFFF,    32'd90, 1'b1};

    // Asynchronous reset at power-up.
    #2 rst_n = 1'b0;
    #1;
    check("rst_angle", angle, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_oor", {31'd0, out_of_range}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Handshake latency: busy from edge N, done exactly at N+7, cleared at N+8.
    start = 1'b1; op_selector = 1'b0; value = 32'd32768;
    e.angle = 32'd30; e.oor = 1'b0; sb.push_back(e);
    @(negedge clk);
    start = 1'b0; value = 32'd1;
    check("lat_busy_0", {31'd0, busy}, 32'd1);
    check("lat_done_0", {31'd0, done}, 32'd0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("lat_busy", {31'd0, busy}, (k < 7) ? 32'd1 : 32'd0);
      check("lat_done", {31'd0, done}, (k == 7) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("lat_done_clear", {31'd0, done}, 32'd0);

    // Vector table, each request issued on the previous done cycle.
    for (int i = 0; i < 14; i++) begin
      e.angle = vecs[i].angle; e.oor = vecs[i].oor;
      run(vecs[i].op, vecs[i].value, e);
    end

    // Every table entry and one LSB above it, alternating sine/cosine.
    for (int d = 0; d <= 90; d++) begin
      run(1'(d % 2), 32'(tbl_m[d]), model(1'(d % 2), 32'(tbl_m[d])));
      if (d < 90)
        run(1'((d + 1) % 2), 32'(tbl_m[d] + 1), model(1'((d + 1) % 2), 32'(tbl_m[d] + 1)));
    end

    // Back-to-back: second request accepted on the first one's done cycle.
    e.angle = 32'd45; e.oor = 1'b0;
    run(1'b0, 32'd46341, e);
    e.angle = 32'd80; e.oor = 1'b0;
    run(1'b1, 32'd11380, e);
    #1;
    check("b2b_gap", 32'(last_done - prev_done), 32'd8);
    @(negedge clk);

    // Busy protection: a second start and value changes mid-search are ignored.
    c0 = done_count;
    e.angle = 32'd15; e.oor = 1'b0;
    issue(1'b0, 32'd16962, e);
    @(negedge clk);
    start = 1'b1; op_selector = 1'b1; value = 32'd50000;
    @(negedge clk);
    start = 1'b0; value = 32'd70000;
    wait_done("busy_timeout");
    #1;
    check("busy_one_done", 32'(done_count - c0), 32'd1);
    repeat (12) @(negedge clk);
    check("busy_no_extra", 32'(done_count - c0), 32'd1);

    // start held high: a new request every 8 cycles.
    c0 = done_count;
    start = 1'b1; op_selector = 1'b1; value = 32'd16962;
    e.angle = 32'd75; e.oor = 1'b0;
    repeat (3) sb.push_back(e);
    for (int i = 0; i < 40 && (done_count - c0) < 3; i++) begin
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    check("held_count", 32'(done_count - c0), 32'd3);
    check("held_gap", 32'(last_done - prev_done), 32'd8);
    repeat (12) @(negedge clk);

    // Reset mid-search: no done, angle cleared, fresh search afterwards.
    e.angle = 32'd30; e.oor = 1'b0;
    run(1'b0, 32'd32768, e);
    e.angle = 32'd90; e.oor = 1'b0;
    issue(1'b0, 32'd65536, e);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_angle", angle, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    c0 = done_count;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("mid_rst_no_done", {31'd0, done}, 32'd0);
    end
    check("mid_rst_angle_hold", angle, 32'd0);
    e.angle = 32'd60; e.oor = 1'b0;
    run(1'b1, 32'd32768, e);
    #1;
    check("mid_rst_one_done", 32'(done_count - c0), 32'd1);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
